// File: rtl/enc_pkg.sv
// Shared constants and state encoding for the sequential 8-to-3 encoder.
// Optional feature macro used by the encoder: ENC_LAST_EN (adds the out_last port).
package enc_pkg;

    localparam int N = 8;
    localparam int W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_t;

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational lowest-set-bit finder: idx is the position of the lowest set
// bit of vec (0 when vec is all-zero); any flags a non-zero vec.
module prio_enc_lsb #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // NOTE: idx gets a default before the loop so every path assigns it and no latch is inferred.
    always_comb begin
        idx = '0;
        // Scan from the top down so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/encoder_8to3_seq.sv
// Sequential 8-to-3 encoder: accepts a request vector over valid/ready and emits
// one index per set bit, lowest first; an all-zero vector yields one flagged beat.
// Build option: define ENC_LAST_EN to add the out_last port and its logic.
module encoder_8to3_seq
    import enc_pkg::*;
#(
    parameter int N = enc_pkg::N,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_zero
`ifdef ENC_LAST_EN
    ,
    output logic         out_last
`endif
);

    enc_state_t   state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic         zflag_q, zflag_d;

    logic [N-1:0] pend_clr;
    logic [W-1:0] low_idx;
    logic         pend_any;

    prio_enc_lsb #(
        .N (N),
        .W (W)
    ) u_prio (
        .vec (pend_q),
        .idx (low_idx),
        .any (pend_any)
    );

    // Pending vector with the currently emitted (lowest) bit removed.
    assign pend_clr = pend_q & (pend_q - N'(1));

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        zflag_d = zflag_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pend_d  = in_vec;
                    zflag_d = (in_vec == '0);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pend_d = pend_clr;
                    // A zero vector has nothing to clear, so zflag alone ends it.
                    if (pend_clr == '0 || zflag_q) begin
                        state_d = IDLE;
                        zflag_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            zflag_q <= zflag_d;
        end
    end

    // Every output decodes registered state only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign out_idx   = low_idx;
    assign out_zero  = zflag_q;

`ifdef ENC_LAST_EN
    assign out_last = out_valid && (zflag_q || (pend_any && pend_clr == '0));
`else
    logic unused_any;
    assign unused_any = pend_any;
`endif

endmodule
